// File: rtl/pic_host_sequencer_if.sv
// PIC pin-level bus between the host sequencer (master) and the PIC (slave).
interface pic_host_sequencer_if;
  logic       INT;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic       D_oe;
  logic       CS;
  logic       WR;
  logic       RD;
  logic       A0;
  logic       INTA;

  modport master (
    input  INT, D_in,
    output D_out, D_oe, CS, WR, RD, A0, INTA
  );

  modport slave (
    output INT, D_in,
    input  D_out, D_oe, CS, WR, RD, A0, INTA
  );
endinterface

// File: rtl/pic_host_sequencer.sv
// Host-side bus master for the PIC: writes ICW1..ICW4/OCW1 after start, then
// answers INT with a two-pulse INTA handshake and captures the vector byte.
// Optional status reads (OCW3 + RD access) are built when PIC_HOST_STATUS_EN is defined.
module pic_host_sequencer #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        start,
  input  logic [7:0]                  cfg_icw1,
  input  logic [7:0]                  cfg_icw2,
  input  logic [7:0]                  cfg_icw3,
  input  logic [7:0]                  cfg_icw4,
  input  logic [7:0]                  cfg_ocw1,
  input  logic                        rd_req,
  input  logic                        rd_sel,
  pic_host_sequencer_if.master        pic,
  output logic                        busy,
  output logic                        init_done,
  output logic [7:0]                  vector,
  output logic                        vector_vld,
  output logic [7:0]                  status,
  output logic                        status_vld
);

  localparam int unsigned MaxCyc = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam logic [CntW-1:0] StrbLast = CntW'(STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StWrSetup, StWrStrobe, StWrHold, StWrGap, StRdStrobe, StRdGap,
    StReady, StAck1, StAckGap, StAck2, StAckTail
  } state_e;

  typedef enum logic [2:0] {
    StepIcw1, StepIcw2, StepIcw3, StepIcw4, StepOcw1, StepOcw3
  } step_e;

  state_e          state_q, state_d;
  step_e           step_q, step_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d;
  logic [7:0]      icw4_q, icw4_d, ocw1_q, ocw1_d;
  logic            rd_sel_q, rd_sel_d;
  logic            init_done_q, init_done_d;
  logic [7:0]      vector_q, vector_d;
  logic            vector_vld_q, vector_vld_d;
  logic [7:0]      status_q, status_d;
  logic            status_vld_q, status_vld_d;
  logic            cs_q, cs_d, wr_q, wr_d, rd_q, rd_d, inta_q, inta_d;
  logic            a0_q, a0_d, d_oe_q, d_oe_d, busy_q, busy_d;
  logic [7:0]      d_out_q, d_out_d;
  logic            begin_init;
  logic [7:0]      wr_data;
  logic            wr_a0;

`ifndef PIC_HOST_STATUS_EN
  logic unused_rd;
  assign unused_rd = rd_req ^ rd_sel;
`endif

  // Next state, then bus outputs derived from the next state so they are registered with it.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    icw1_d       = icw1_q;
    icw2_d       = icw2_q;
    icw3_d       = icw3_q;
    icw4_d       = icw4_q;
    ocw1_d       = ocw1_q;
    rd_sel_d     = rd_sel_q;
    init_done_d  = init_done_q;
    vector_d     = vector_q;
    vector_vld_d = 1'b0;
    status_d     = status_q;
    status_vld_d = 1'b0;
    begin_init   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin_init = 1'b1;
      end
      StReady: begin
        if (start) begin
          begin_init = 1'b1;
        end else if (pic.INT) begin
          state_d = StAck1;
          cnt_d   = '0;
        end
`ifdef PIC_HOST_STATUS_EN
        else if (rd_req) begin
          rd_sel_d = rd_sel;
          step_d   = StepOcw3;
          state_d  = StWrSetup;
          cnt_d    = '0;
        end
`endif
      end
      StWrSetup: begin
        state_d = StWrStrobe;
        cnt_d   = '0;
      end
      StWrStrobe: begin
        if (cnt_q == StrbLast) begin
          state_d = StWrHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrHold: begin
        state_d = StWrGap;
        cnt_d   = '0;
      end
      StWrGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StWrSetup;
          case (step_q)
            StepIcw1: step_d = StepIcw2;
            StepIcw2: step_d = !icw1_q[1] ? StepIcw3 : (icw1_q[0] ? StepIcw4 : StepOcw1);
            StepIcw3: step_d = icw1_q[0] ? StepIcw4 : StepOcw1;
            StepIcw4: step_d = StepOcw1;
            StepOcw1: begin
              state_d     = StReady;
              init_done_d = 1'b1;
            end
            default:  state_d = StRdStrobe;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRdStrobe: begin
        if (cnt_q == StrbLast) begin
`ifdef PIC_HOST_STATUS_EN
          status_d     = pic.D_in;
          status_vld_d = 1'b1;
`endif
          state_d = StRdGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRdGap: begin
        if (cnt_q == GapLast) begin
          state_d = StReady;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck1: begin
        if (cnt_q == StrbLast) begin
          state_d = StAckGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAckGap: begin
        if (cnt_q == GapLast) begin
          state_d = StAck2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck2: begin
        // INT is not re-checked here: a dropped request still gets its second pulse.
        if (cnt_q == StrbLast) begin
          vector_d     = pic.D_in;
          vector_vld_d = 1'b1;
          state_d      = StAckTail;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAckTail: begin
        if (cnt_q == GapLast) begin
          state_d = StReady;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (begin_init) begin
      icw1_d      = cfg_icw1;
      icw2_d      = cfg_icw2;
      icw3_d      = cfg_icw3;
      icw4_d      = cfg_icw4;
      ocw1_d      = cfg_ocw1;
      init_done_d = 1'b0;
      step_d      = StepIcw1;
      state_d     = StWrSetup;
      cnt_d       = '0;
    end

    case (step_d)
      StepIcw1: begin wr_data = icw1_d; wr_a0 = 1'b0; end
      StepIcw2: begin wr_data = icw2_d; wr_a0 = 1'b1; end
      StepIcw3: begin wr_data = icw3_d; wr_a0 = 1'b1; end
      StepIcw4: begin wr_data = icw4_d; wr_a0 = 1'b1; end
      StepOcw1: begin wr_data = ocw1_d; wr_a0 = 1'b1; end
      default:  begin wr_data = {6'b000010, 1'b1, rd_sel_d}; wr_a0 = 1'b0; end
    endcase

    cs_d    = 1'b1;
    wr_d    = 1'b1;
    rd_d    = 1'b1;
    inta_d  = 1'b0;
    d_oe_d  = 1'b0;
    a0_d    = a0_q;
    d_out_d = d_out_q;
    case (state_d)
      StWrSetup, StWrHold: begin
        cs_d    = 1'b0;
        d_oe_d  = 1'b1;
        a0_d    = wr_a0;
        d_out_d = wr_data;
      end
      StWrStrobe: begin
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        d_oe_d  = 1'b1;
        a0_d    = wr_a0;
        d_out_d = wr_data;
      end
      StRdStrobe: begin
        cs_d = 1'b0;
        rd_d = 1'b0;
        a0_d = 1'b0;
      end
      StAck1, StAck2: inta_d = 1'b1;
      default: ;
    endcase
    busy_d = !((state_d == StIdle) || (state_d == StReady));
  end

  // State and registered outputs; synchronous reset aborts any access on the next edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      step_q       <= StepIcw1;
      cnt_q        <= '0;
      icw1_q       <= '0;
      icw2_q       <= '0;
      icw3_q       <= '0;
      icw4_q       <= '0;
      ocw1_q       <= '0;
      rd_sel_q     <= 1'b0;
      init_done_q  <= 1'b0;
      vector_q     <= '0;
      vector_vld_q <= 1'b0;
      status_q     <= '0;
      status_vld_q <= 1'b0;
      cs_q         <= 1'b1;
      wr_q         <= 1'b1;
      rd_q         <= 1'b1;
      inta_q       <= 1'b0;
      a0_q         <= 1'b0;
      d_oe_q       <= 1'b0;
      d_out_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      icw1_q       <= icw1_d;
      icw2_q       <= icw2_d;
      icw3_q       <= icw3_d;
      icw4_q       <= icw4_d;
      ocw1_q       <= ocw1_d;
      rd_sel_q     <= rd_sel_d;
      init_done_q  <= init_done_d;
      vector_q     <= vector_d;
      vector_vld_q <= vector_vld_d;
      status_q     <= status_d;
      status_vld_q <= status_vld_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      inta_q       <= inta_d;
      a0_q         <= a0_d;
      d_oe_q       <= d_oe_d;
      d_out_q      <= d_out_d;
      busy_q       <= busy_d;
    end
  end

  assign pic.CS    = cs_q;
  assign pic.WR    = wr_q;
  assign pic.RD    = rd_q;
  assign pic.INTA  = inta_q;
  assign pic.A0    = a0_q;
  assign pic.D_oe  = d_oe_q;
  assign pic.D_out = d_out_q;
  assign busy       = busy_q;
  assign init_done  = init_done_q;
  assign vector     = vector_q;
  assign vector_vld = vector_vld_q;
  assign status     = status_q;
  assign status_vld = status_vld_q;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Scoreboard bench for pic_host_sequencer: expected bus writes / vectors are queued
// when stimulus is applied and compared against what a pin monitor observes.
module tb_pic_host_sequencer;
  localparam int unsigned Stb = 3;
  localparam int unsigned Gap = 2;

  typedef struct {
    logic       a0;
    logic [7:0] data;
    int         len;
    bit         bus_ok;
  } wr_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cfg_icw1 = '0, cfg_icw2 = '0, cfg_icw3 = '0, cfg_icw4 = '0, cfg_ocw1 = '0;
  logic       rd_req = 1'b0, rd_sel = 1'b0;
  logic       busy, init_done, vector_vld, status_vld;
  logic [7:0] vector, status;
  logic       int_req = 1'b0;
  logic [7:0] vec_val = '0, stat_val = '0;

  int n_checks = 0;
  int n_pass   = 0;

  wr_t        exp_wr[$], obs_wr[$];
  int         obs_inta[$];
  logic [7:0] obs_vec[$], obs_stat[$];
  int         wr_len = 0, inta_len = 0, inta_cycles = 0, rd_cycles = 0, vld_double = 0;
  bit         cur_ok = 1'b1, inta_ok = 1'b1, vld_prev = 1'b0;
  logic       cur_a0 = 1'b0;
  logic [7:0] cur_data = '0;

  pic_host_sequencer_if ifc ();

  assign ifc.INT  = int_req;
  // PIC model: vector byte while INTA is high, status byte while RD is low.
  assign ifc.D_in = ifc.INTA ? vec_val : (!ifc.RD ? stat_val : 8'h00);

  pic_host_sequencer #(
    .STROBE_CYCLES (Stb),
    .GAP_CYCLES    (Gap)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start),
    .cfg_icw1   (cfg_icw1),
    .cfg_icw2   (cfg_icw2),
    .cfg_icw3   (cfg_icw3),
    .cfg_icw4   (cfg_icw4),
    .cfg_ocw1   (cfg_ocw1),
    .rd_req     (rd_req),
    .rd_sel     (rd_sel),
    .pic        (ifc.master),
    .busy       (busy),
    .init_done  (init_done),
    .vector     (vector),
    .vector_vld (vector_vld),
    .status     (status),
    .status_vld (status_vld)
  );

  always #5 CLK = ~CLK;

  // Pin monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (!ifc.WR) begin
      wr_len   = wr_len + 1;
      cur_a0   = ifc.A0;
      cur_data = ifc.D_out;
      if (ifc.CS || !ifc.D_oe) cur_ok = 1'b0;
    end else if (wr_len > 0) begin
      obs_wr.push_back('{cur_a0, cur_data, wr_len, cur_ok});
      wr_len = 0;
      cur_ok = 1'b1;
    end
    if (ifc.INTA) begin
      inta_len    = inta_len + 1;
      inta_cycles = inta_cycles + 1;
      if (!ifc.CS || ifc.D_oe) inta_ok = 1'b0;
    end else if (inta_len > 0) begin
      obs_inta.push_back(inta_len);
      inta_len = 0;
    end
    if (!ifc.RD) rd_cycles = rd_cycles + 1;
    if (vector_vld) obs_vec.push_back(vector);
    if (vector_vld && vld_prev) vld_double = vld_double + 1;
    vld_prev = vector_vld;
    if (status_vld) obs_stat.push_back(status);
  end

  task automatic flush();
    exp_wr.delete();
    obs_wr.delete();
    obs_inta.delete();
    obs_vec.delete();
    obs_stat.delete();
    inta_cycles = 0;
    rd_cycles   = 0;
    vld_double  = 0;
    inta_ok     = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // Compare observed writes against the expected queue.
  task automatic compare_writes(input string tag);
    n_checks++;
    if (obs_wr.size() !== exp_wr.size())
      $display("FAIL %s write_count got=%0d exp=%0d", tag, obs_wr.size(), exp_wr.size());
    else n_pass++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      wr_t e, o;
      e = exp_wr.pop_front();
      o = obs_wr.pop_front();
      n_checks++;
      if ({o.a0, o.data} !== {e.a0, e.data})
        $display("FAIL %s write a0/data got=%b/%h exp=%b/%h", tag, o.a0, o.data, e.a0, e.data);
      else n_pass++;
      n_checks++;
      if (o.len !== Stb) $display("FAIL %s wr_low_len got=%0d exp=%0d", tag, o.len, Stb);
      else n_pass++;
      n_checks++;
      if (o.bus_ok !== 1'b1) $display("FAIL %s cs/oe_during_wr got=0 exp=1", tag);
      else n_pass++;
    end
  endtask

  // Program the PIC; expected writes come from the ICW1 SNGL/IC4 bits.
  task automatic run_init(input string tag, input logic [7:0] i1, input logic [7:0] i2,
                          input logic [7:0] i3, input logic [7:0] i4, input logic [7:0] o1);
    bit done = 1'b0;
    flush();
    exp_wr.push_back('{1'b0, i1, Stb, 1'b1});
    exp_wr.push_back('{1'b1, i2, Stb, 1'b1});
    if (!i1[1]) exp_wr.push_back('{1'b1, i3, Stb, 1'b1});
    if (i1[0]) exp_wr.push_back('{1'b1, i4, Stb, 1'b1});
    exp_wr.push_back('{1'b1, o1, Stb, 1'b1});
    cfg_icw1 = i1; cfg_icw2 = i2; cfg_icw3 = i3; cfg_icw4 = i4; cfg_ocw1 = o1;
    pulse_start();
    n_checks++;
    if ({init_done, busy} !== 2'b01)
      $display("FAIL %s after_start init_done/busy got=%b%b exp=01", tag, init_done, busy);
    else n_pass++;
    // Later cfg changes and a start while busy must not disturb the sequence.
    cfg_icw1 = ~i1; cfg_icw2 = ~i2; cfg_icw3 = ~i3; cfg_icw4 = ~i4; cfg_ocw1 = ~o1;
    repeat (4) @(posedge CLK);
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (init_done) begin done = 1'b1; break; end
    end
    n_checks++;
    if (!done) $display("FAIL %s init_timeout got=0 exp=1", tag);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s busy_in_ready got=%b exp=0", tag, busy);
    else n_pass++;
    compare_writes(tag);
  endtask

  task automatic wait_vectors(input int n);
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK);
      if (obs_vec.size() >= n) break;
    end
  endtask

  task automatic check_ack(input string tag, input logic [7:0] exp_vec);
    n_checks++;
    if (obs_inta.size() !== 2) $display("FAIL %s inta_pulses got=%0d exp=2", tag, obs_inta.size());
    else n_pass++;
    foreach (obs_inta[i]) begin
      n_checks++;
      if (obs_inta[i] !== Stb)
        $display("FAIL %s inta_len[%0d] got=%0d exp=%0d", tag, i, obs_inta[i], Stb);
      else n_pass++;
    end
    n_checks++;
    if (obs_vec.size() !== 1) $display("FAIL %s vector_count got=%0d exp=1", tag, obs_vec.size());
    else n_pass++;
    if (obs_vec.size() > 0) begin
      n_checks++;
      if (obs_vec[0] !== exp_vec) $display("FAIL %s vector got=%h exp=%h", tag, obs_vec[0], exp_vec);
      else n_pass++;
    end
    n_checks++;
    if (vld_double !== 0) $display("FAIL %s vector_vld_width got=%0d exp=0", tag, vld_double);
    else n_pass++;
    n_checks++;
    if (inta_ok !== 1'b1) $display("FAIL %s cs/oe_during_inta got=0 exp=1", tag);
    else n_pass++;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if ({ifc.CS, ifc.WR, ifc.RD, ifc.INTA, ifc.A0, ifc.D_oe} !== 6'b111000)
      $display("FAIL reset pins got=%b exp=111000",
               {ifc.CS, ifc.WR, ifc.RD, ifc.INTA, ifc.A0, ifc.D_oe});
    else n_pass++;
    n_checks++;
    if ({busy, init_done, vector_vld, status_vld} !== 4'b0000)
      $display("FAIL reset flags got=%b exp=0000", {busy, init_done, vector_vld, status_vld});
    else n_pass++;
    n_checks++;
    if ({ifc.D_out, vector, status} !== 24'h0)
      $display("FAIL reset data got=%h exp=000000", {ifc.D_out, vector, status});
    else n_pass++;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic test_int_ack();
    flush();
    vec_val = 8'hAB;
    @(posedge CLK); #1;
    int_req = 1'b1;
    wait_vectors(1);
    #1 int_req = 1'b0;
    repeat (20) @(posedge CLK);
    check_ack("int_ack", 8'hAB);
  endtask

  task automatic test_int_drop();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    flush();
    int_req = 1'b1;
    repeat (20) @(posedge CLK);
    #1 int_req = 1'b0;
    n_checks++;
    if (inta_cycles !== 0 || busy !== 1'b0)
      $display("FAIL idle_int inta_cycles/busy got=%0d/%b exp=0/0", inta_cycles, busy);
    else n_pass++;
    run_init("drop_init", 8'h13, 8'h40, 8'h00, 8'h01, 8'hFF);
    n_checks++;
    if (inta_cycles !== 0) $display("FAIL drop_init inta_cycles got=%0d exp=0", inta_cycles);
    else n_pass++;
    flush();
    vec_val = 8'h5C;
    int_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (ifc.INTA) break;
    end
    int_req = 1'b0;
    wait_vectors(1);
    repeat (20) @(posedge CLK);
    check_ack("int_drop", 8'h5C);
  endtask

  task automatic test_status();
    flush();
`ifdef PIC_HOST_STATUS_EN
    stat_val = 8'h08;
    rd_sel = 1'b1;
    @(posedge CLK); #1;
    rd_req = 1'b1;
    @(posedge CLK); #1;
    rd_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      if (obs_stat.size() > 0) break;
    end
    repeat (10) @(posedge CLK);
    exp_wr.push_back('{1'b0, 8'h0B, Stb, 1'b1});
    compare_writes("status_ocw3");
    n_checks++;
    if (obs_stat.size() !== 1) $display("FAIL status_count got=%0d exp=1", obs_stat.size());
    else n_pass++;
    n_checks++;
    if (status !== 8'h08) $display("FAIL status_value got=%h exp=08", status);
    else n_pass++;
    n_checks++;
    if (rd_cycles !== Stb) $display("FAIL status_rd_len got=%0d exp=%0d", rd_cycles, Stb);
    else n_pass++;
`else
    stat_val = 8'h08;
    rd_sel = 1'b1;
    @(posedge CLK); #1;
    rd_req = 1'b1;
    repeat (30) @(posedge CLK);
    #1 rd_req = 1'b0;
    n_checks++;
    if (obs_wr.size() !== 0) $display("FAIL status_off writes got=%0d exp=0", obs_wr.size());
    else n_pass++;
    n_checks++;
    if (rd_cycles !== 0) $display("FAIL status_off rd_low got=%0d exp=0", rd_cycles);
    else n_pass++;
    n_checks++;
    if ({status, status_vld, busy} !== 10'h0 || obs_stat.size() !== 0)
      $display("FAIL status_off status/vld/busy got=%h/%b/%b exp=00/0/0", status, status_vld, busy);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    flush();
    cfg_icw1 = 8'h1B; cfg_icw2 = 8'hA8; cfg_icw3 = 8'h00; cfg_icw4 = 8'h02; cfg_ocw1 = 8'h80;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!ifc.WR && ifc.A0) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit) $display("FAIL reset_mid icw2_strobe_seen got=0 exp=1");
    else n_pass++;
    RESET = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if ({ifc.CS, ifc.WR, ifc.D_oe, init_done, busy} !== 5'b11000)
      $display("FAIL reset_mid cs/wr/oe/init_done/busy got=%b exp=11000",
               {ifc.CS, ifc.WR, ifc.D_oe, init_done, busy});
    else n_pass++;
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (10) @(posedge CLK);
    n_checks++;
    if ({ifc.CS, busy} !== 2'b10) $display("FAIL reset_mid idle got=%b exp=10", {ifc.CS, busy});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    run_init("init_no_icw3", 8'h1B, 8'hA8, 8'h55, 8'h02, 8'h80);
    test_int_ack();
    run_init("init_icw3", 8'h19, 8'h20, 8'h02, 8'h01, 8'h00);
    run_init("init_no_icw4", 8'h10, 8'h68, 8'h04, 8'h3C, 8'hF0);
    test_status();
    test_int_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
